// File: rtl/knap_search.sv
// rtl/knap_search.sv - sequential knapsack solver walking every subset mask, one per clock
// Optional KNAP_EARLY_EXIT_EN: stop at the first valid subset (satisfiability mode).
module knap_search #(
  parameter int N_ITEMS = 5,
  parameter int VAL_W   = 8,
  parameter int WT_W    = 8,
  parameter int SUM_W   = 12,
  localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
  localparam int VC_W   = N_ITEMS + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               item_we,
  input  logic [IDX_W-1:0]   item_idx,
  input  logic [VAL_W-1:0]   item_value,
  input  logic [WT_W-1:0]    item_weight,
  input  logic [VAL_W-1:0]   min_value,
  input  logic [WT_W-1:0]    max_weight,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [SUM_W-1:0]   best_value,
  output logic [SUM_W-1:0]   best_weight,
  output logic [VC_W-1:0]    valid_count
);

  localparam int MAX_W = (VAL_W > WT_W) ? VAL_W : WT_W;

  if (N_ITEMS < 1 || N_ITEMS > 16) begin : g_bad_items
    $error("knap_search: N_ITEMS must be in 1..16");
  end
  if (SUM_W < MAX_W + $clog2(N_ITEMS)) begin : g_bad_sum
    $error("knap_search: SUM_W too narrow to hold a full-subset sum");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              state_q;
  logic [N_ITEMS-1:0]  mask_q;
  logic [VAL_W-1:0]    min_q;
  logic [WT_W-1:0]     maxw_q;
  logic [VAL_W-1:0]    val_q [N_ITEMS];
  logic [WT_W-1:0]     wt_q  [N_ITEMS];
  logic                busy_q;
  logic                done_q;
  logic                found_q;
  logic [N_ITEMS-1:0]  best_mask_q;
  logic [SUM_W-1:0]    best_value_q;
  logic [SUM_W-1:0]    best_weight_q;
  logic [VC_W-1:0]     valid_count_q;

  logic [SUM_W-1:0]    tv;
  logic [SUM_W-1:0]    tw;
  logic                valid;
  logic                better;

  always_comb begin
    tv = '0;
    tw = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask_q[i]) begin
        tv = tv + SUM_W'(val_q[i]);
        tw = tw + SUM_W'(wt_q[i]);
      end
    end
  end

  assign valid  = (tv >= SUM_W'(min_q)) && (tw <= SUM_W'(maxw_q));
  // Strict compares keep the lower mask on a full tie, since masks are visited in ascending order.
  assign better = !found_q || (tv > best_value_q) ||
                  ((tv == best_value_q) && (tw < best_weight_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      min_q         <= '0;
      maxw_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      best_mask_q   <= '0;
      best_value_q  <= '0;
      best_weight_q <= '0;
      valid_count_q <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        val_q[i] <= '0;
        wt_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (item_we && (int'(item_idx) < N_ITEMS)) begin
            val_q[item_idx] <= item_value;
            wt_q[item_idx]  <= item_weight;
          end
          if (start) begin
            state_q       <= S_SCAN;
            busy_q        <= 1'b1;
            mask_q        <= '0;
            min_q         <= min_value;
            maxw_q        <= max_weight;
            found_q       <= 1'b0;
            best_mask_q   <= '0;
            best_value_q  <= '0;
            best_weight_q <= '0;
            valid_count_q <= '0;
          end
        end
        S_SCAN: begin
          if (valid) begin
            valid_count_q <= valid_count_q + VC_W'(1);
            if (better) begin
              found_q       <= 1'b1;
              best_mask_q   <= mask_q;
              best_value_q  <= tv;
              best_weight_q <= tw;
            end
          end
`ifdef KNAP_EARLY_EXIT_EN
          if (valid || (mask_q == '1)) begin
`else
          if (mask_q == '1) begin
`endif
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            mask_q <= mask_q + N_ITEMS'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign best_mask   = best_mask_q;
  assign best_value  = best_value_q;
  assign best_weight = best_weight_q;
  assign valid_count = valid_count_q;

endmodule
